// File: rtl/copro_horner_seq.sv
// Horner-rule polynomial sequencer driving an external 9.7 fixed-point MAC (d = a*b + c).
// Holds eight coefficients, the argument x and the degree; issues one MAC operation per step.
module copro_horner_seq #(
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic signed [15:0] wr_data,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] result,
  output logic signed [15:0] mac_a,
  output logic signed [15:0] mac_b,
  output logic signed [15:0] mac_c,
  input  logic signed [15:0] mac_d
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(MAC_LAT + 2);

  typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] coef [8];
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] acc;
  logic [2:0]               degree;
  logic [2:0]               idx;
  logic [CNT_W-1:0]         wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mac_a  <= '0;
      mac_b  <= '0;
      mac_c  <= '0;
      acc    <= '0;
      x      <= '0;
      degree <= '0;
      idx    <= '0;
      wcnt   <= '0;
      for (int i = 0; i < 8; i++) coef[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Start reads the pre-write register values; a simultaneous write still commits.
          if (wr_en) begin
            if (wr_addr[3] == 1'b0)
              coef[wr_addr[2:0]] <= wr_data;
            else if (wr_addr == 4'd8)
              x <= wr_data;
            else if (wr_addr == 4'd9)
              degree <= wr_data[2:0];
          end
          if (start) begin
            acc   <= coef[degree];
            idx   <= degree;
            busy  <= 1'b1;
            state <= STEP;
          end
        end

        STEP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == 3'd0) begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            mac_a <= acc;
            mac_b <= x;
            mac_c <= coef[idx - 3'd1];
            idx   <= idx - 3'd1;
            wcnt  <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          // Operands stay frozen here so the MAC sees stable inputs for its full latency.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wcnt == CNT_W'(MAC_LAT)) begin
            acc   <= mac_d;
            state <= STEP;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_copro_horner_seq.sv
// Scoreboard bench for copro_horner_seq with a one-register 9.7 MAC model (MAC_LAT=1).
module tb_copro_horner_seq;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, abort;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, done;
  logic [15:0] result, mac_a, mac_b, mac_c;
  logic [15:0] mac_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] res;
    int          at;
  } exp_t;
  exp_t q[$];

  copro_horner_seq #(.MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .result(result),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[22:7] + c;
  endfunction

  always @(posedge clk) mac_d <= mac_fn(mac_a, mac_b, mac_c);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.at);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input bit expect_done, input logic [15:0] res, input int deg);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (expect_done) q.push_back('{res, cyc + 1 + deg * 3});
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_mac_a", mac_a, 16'h0000);

    // Degree 1: 1.0*3.0 + 2.0 = 5.0
    wr(4'd1, 16'h0080); wr(4'd0, 16'h0100); wr(4'd8, 16'h0180); wr(4'd9, 16'd1);
    do_start(1'b1, 16'h0280, 1);
    tick();
    chk("d1_mac_a", mac_a, 16'h0080);
    chk("d1_mac_b", mac_b, 16'h0180);
    chk("d1_mac_c", mac_c, 16'h0100);
    wait_idle(50);

    // Degree 2: (1.0*2.0 - 1.0)*2.0 + 0.5 = 2.5
    wr(4'd2, 16'h0080); wr(4'd1, 16'hFF80); wr(4'd0, 16'h0040); wr(4'd8, 16'h0100);
    wr(4'd9, 16'd2);
    do_start(1'b1, 16'h0140, 2);
    for (int i = 0; i < 7; i++) begin
      chk("d2_busy", busy, 1'b1);
      if (i == 4) begin
        chk("d2_intermediate_acc", mac_a, 16'h0080);
        chk("d2_mac_c2", mac_c, 16'h0040);
      end
      tick();
    end
    chk("d2_busy_end", busy, 1'b0);
    wait_idle(50);

    // Degree 0 with a write in the start cycle
    wr(4'd9, 16'd0); wr(4'd0, 16'h1234);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5678;
    do_start(1'b1, 16'h1234, 0);
    wr_en = 1'b0;
    wait_idle(50);
    chk("coll_mac_a", mac_a, 16'h0080);
    chk("coll_mac_b", mac_b, 16'h0100);
    chk("coll_mac_c", mac_c, 16'h0040);
    do_start(1'b1, 16'h5678, 0);
    wait_idle(50);

    // Start and write while busy are dropped
    wr(4'd0, 16'h0040); wr(4'd9, 16'd2);
    do_start(1'b1, 16'h0140, 2);
    tick(); tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h7FFF;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_idle(50);
    repeat (10) tick();
    chk("busy_prot_result", result, 16'h0140);
    wr(4'd9, 16'd0);
    do_start(1'b1, 16'h0040, 0);
    wait_idle(50);

    // Abort mid-run; result from the previous run survives
    wr(4'd9, 16'd2);
    do_start(1'b0, 16'h0000, 2);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'h0040);
    repeat (10) tick();
    do_start(1'b1, 16'h0140, 2);
    wait_idle(50);

    // Reset during WAIT
    do_start(1'b0, 16'h0000, 2);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_result", result, 16'h0000);
    chk("mrst_mac_a", mac_a, 16'h0000);
    chk("mrst_mac_b", mac_b, 16'h0000);
    chk("mrst_mac_c", mac_c, 16'h0000);
    rst = 1'b0;
    wr(4'd9, 16'd7);
    do_start(1'b1, 16'h0000, 7);
    wait_idle(100);
    wr(4'd9, 16'd0);
    do_start(1'b1, 16'h0000, 0);
    wait_idle(50);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/copro_horner_seq.md
# copro_horner_seq

Sequencer for the coprocessor's fixed-point multiply-add unit, computing d = a*b + c in 9.7 two's complement. It holds a bank of up to eight 16-bit coefficients and an argument x, and evaluates the polynomial c[n]·xⁿ + … + c[0] by Horner's rule. Each Horner step is issued as one operation to the external MAC, and the block waits a fixed MAC latency for each result. It sits between the Z80-facing register logic (host port) and the MAC instance, which it drives exclusively.

## Interface
Parameters:
- MAC_LAT, default 1. Number of clock edges from a stable MAC input to a valid registered output.

Ports:
- clk  in  1  master clock (clk28 domain); single clock for the whole block
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  host write strobe, one cycle per write
- wr_addr  in  4  0–7 select coef[0..7]; 8 selects x; 9 selects degree (low 3 bits of wr_data); 10–15 are ignored
- wr_data  in  16  write data, signed 9.7
- start  in  1  one-cycle request to evaluate
- abort  in  1  cancel an evaluation in progress
- busy  out  1  high while an evaluation is in progress
- done  out  1  one-cycle pulse when the result is valid
- result  out  16  last completed result, signed 9.7
- mac_a, mac_b, mac_c  out  16 each  registered MAC operands
- mac_d  in  16  MAC result (d = a*b + c)

## Operation
- States: IDLE, STEP, WAIT. Internal registers:
  - acc (16 bits)
  - idx (3 bits)
  - wait counter (sized for MAC_LAT+1)
- **Writes:**
  - Accepted only in IDLE and committed at the clock edge.
  - Writes while busy are dropped silently.
  - wr_addr 10–15 is a no-op.
- **IDLE:**
  - When start=1, the block performs all of the following at the same edge: acc ← coef[degree], idx ← degree, busy ← 1, state goes to STEP.
  - If start and wr_en occur in the same cycle, the evaluation uses the pre-write values.
- **STEP:**
  - If idx = 0: result ← acc, done ← 1, busy ← 0, state goes to IDLE.
  - Otherwise: mac_a ← acc, mac_b ← x, mac_c ← coef[idx-1], idx ← idx-1, wait counter ← 0, state goes to WAIT.
- **WAIT:**
  - mac_a, mac_b and mac_c are held constant.
  - At the (MAC_LAT+1)-th edge after entering WAIT: acc ← mac_d, state goes to STEP.
- **Arithmetic:**
  - The MAC alone performs the arithmetic; the block does no math of its own.
  - Overflow wraps exactly as the MAC produces it; there is no saturation.
  - result is bit-identical to chaining MAC operations.
- start while busy is ignored and does not queue.
- **abort:**
  - Effective in STEP or WAIT: state goes to IDLE, busy ← 0, no done pulse, result unchanged.
  - abort in IDLE is a no-op.
  - If abort and start occur in the same cycle in IDLE, start wins.
- result holds its value until the next completed evaluation.
- **Reset:**
  - rst has priority over every other input, including mid-evaluation.
  - Values after reset: state IDLE, busy 0, done 0, result 0, mac_a, mac_b and mac_c 0, acc 0, coef[0..7] 0, x 0, degree 0.

## Timing
- Let S be the edge at which start is sampled in IDLE.
  - busy is high from S until the edge that raises done; it is low in the same cycle done is high.
  - done is high for exactly one cycle, beginning at edge S + 1 + degree·(MAC_LAT+2).
- Each Horner step costs MAC_LAT+2 cycles: one STEP cycle plus MAC_LAT+1 WAIT cycles.
- **Latency, MAC_LAT=1:**
  - Degree 0: done at S+1.
  - Degree 2: done at S+7.
  - Degree 7: done at S+22.
- mac_* outputs change only on STEP→WAIT edges. They never change while the MAC result is pending.
- A new start is accepted in the cycle done is high, since the block is already in IDLE.
- Host writes have zero latency: a value written at edge E is used by a start sampled at E+1 or later.

## Test plan
- **Degree 1:**
  - Stimulus: coef[1]=0x0080 (1.0), coef[0]=0x0100 (2.0), x=0x0180 (3.0), degree=1, start.
  - Required: result=0x0280 (5.0), done at S+4, mac_a=0x0080, mac_b=0x0180, mac_c=0x0100 during WAIT.
- **Degree 2:**
  - Stimulus: coef[2]=0x0080, coef[1]=0xFF80 (-1.0), coef[0]=0x0040 (0.5), x=0x0100 (2.0), start.
  - Required: intermediate acc=0x0080, result=0x0140 (2.5), done at S+7, busy high S..S+6.
- **Degree 0 with write collision:**
  - Stimulus: degree=0, coef[0]=0x1234; then in one cycle, start together with a write of coef[0]=0x5678.
  - Required: result=0x1234 at S+1, no MAC operands change, and coef[0] reads as 0x5678 for the next start.
- **Busy protection:**
  - Stimulus: during a degree-2 run, issue start and a coef[0]=0x7FFF write.
  - Required: both are ignored, result is still 0x0140, and exactly one done pulse occurs.
- **Abort:**
  - Stimulus: degree-2 run, then abort at S+3.
  - Required: busy=0 at S+4, no done, result keeps its previous value; a new start then completes normally.
- **Reset mid-evaluation:**
  - Stimulus: rst=1 during WAIT.
  - Required: the next cycle shows busy=0, done=0, result=0, mac_a, mac_b and mac_c 0, all coefficients 0; then a degree-0 start yields result 0x0000 at S+1.
